// File: rtl/sample_acquisition_az_multi_if.sv
// ADC measurement handshake: trigger out to the converter, done pulse back.
interface sample_acquisition_az_multi_if;
    logic adc_measure_trig_o;
    logic adc_measure_valid_i;

    modport master (output adc_measure_trig_o, input adc_measure_valid_i);
    modport slave  (input adc_measure_trig_o, output adc_measure_valid_i);
endinterface

// File: rtl/sample_acquisition_az_multi.sv
// Multi-channel autozero acquisition sequencer. Walks the active hi-side azmux
// channels, optionally pairing each hi sample with a lo (AZ) sample, with a
// precharge settle phase ahead of every ADC trigger.
module sample_acquisition_az_multi #(
    parameter int NCHAN   = 4,
    parameter int AZMUX_W = 4,
    parameter int PC_W    = 2,
    parameter int CNT_W   = 24,
    parameter int IDX_W   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    sample_acquisition_az_multi_if.master adc,
    input  logic                       arm_trigger_i,
    input  logic                       az_enable_i,
    input  logic [AZMUX_W-1:0]         p_azmux_lo_val_i,
    input  logic [NCHAN*AZMUX_W-1:0]   p_azmux_hi_vals_i,
    input  logic [IDX_W:0]             p_chan_count_i,
    input  logic [PC_W-1:0]            p_sw_pc_ctl_hi_val_i,
    input  logic [CNT_W-1:0]           p_clk_count_precharge_i,
    output logic [AZMUX_W-1:0]         azmux_o,
    output logic [PC_W-1:0]            sw_pc_ctl_o,
    output logic [IDX_W-1:0]           chan_idx_o,
    output logic [2:0]                 status_o,
    output logic                       led0_o,
    output logic [1:0]                 monitor_o
);
    localparam int NSLOT = 1 << IDX_W;
    localparam logic [IDX_W:0] NCHAN_C = (IDX_W+1)'(NCHAN);

    typedef enum logic [2:0] {IDLE, HI_PC, HI_MEAS, LO_PC, LO_MEAS, NEXT} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [IDX_W:0]     count_q, count_n, eff_cnt;
    logic               az_q, az_n;
    logic [IDX_W-1:0]   chan_n;
    logic [AZMUX_W-1:0] azmux_n;
    logic [PC_W-1:0]    swpc_n;
    logic               trig_q, trig_n, tog_q, tog_n, led_n;
    logic               last_chan, running, phase_lo, valid_ok;
    logic [AZMUX_W-1:0] hi_arr [NSLOT];

    // Unpack the live hi-side values; slots past NCHAN read as 0.
    genvar k;
    for (k = 0; k < NSLOT; k++) begin : g_hi
        if (k < NCHAN) begin : g_used
            assign hi_arr[k] = p_azmux_hi_vals_i[k*AZMUX_W +: AZMUX_W];
        end else begin : g_pad
            assign hi_arr[k] = '0;
        end
    end

    // Effective channel count: 0 means one channel, anything above NCHAN clamps.
    always_comb begin
        eff_cnt = count_q;
        if (count_q == '0)
            eff_cnt = {{IDX_W{1'b0}}, 1'b1};
        else if (count_q > NCHAN_C)
            eff_cnt = NCHAN_C;
    end

    assign last_chan = ({1'b0, chan_idx_o} == (eff_cnt - 1'b1));
    // A done pulse coinciding with our own trigger belongs to no conversion of ours.
    assign valid_ok  = adc.adc_measure_valid_i && !trig_q;
    assign running   = (state != IDLE);
    assign phase_lo  = (state == LO_PC) || (state == LO_MEAS);

    assign adc.adc_measure_trig_o = trig_q;
    assign status_o  = {tog_q, phase_lo, running};
    assign monitor_o = {trig_q, phase_lo};

    // Next-state and next-output decode; outputs are registered so reset drives them to 0.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        count_n = count_q;
        az_n    = az_q;
        chan_n  = chan_idx_o;
        azmux_n = azmux_o;
        swpc_n  = sw_pc_ctl_o;
        trig_n  = 1'b0;
        tog_n   = tog_q;
        led_n   = led0_o;
        case (state)
            IDLE: begin
                azmux_n = p_azmux_lo_val_i;
                swpc_n  = '0;
                if (arm_trigger_i) begin
                    count_n = p_chan_count_i;
                    az_n    = az_enable_i;
                    chan_n  = '0;
                    cnt_n   = p_clk_count_precharge_i;
                    azmux_n = hi_arr[0];
                    state_n = HI_PC;
                end
            end
            HI_PC: begin
                azmux_n = hi_arr[chan_idx_o];
                swpc_n  = '0;
                if (cnt == '0) begin
                    swpc_n  = p_sw_pc_ctl_hi_val_i;
                    trig_n  = 1'b1;
                    state_n = HI_MEAS;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            HI_MEAS: begin
                if (valid_ok) begin
                    if (az_q) begin
                        cnt_n   = p_clk_count_precharge_i;
                        azmux_n = p_azmux_lo_val_i;
                        swpc_n  = '0;
                        state_n = LO_PC;
                    end else begin
                        state_n = NEXT;
                    end
                end
            end
            LO_PC: begin
                azmux_n = p_azmux_lo_val_i;
                swpc_n  = '0;
                if (cnt == '0) begin
                    trig_n  = 1'b1;
                    state_n = LO_MEAS;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            LO_MEAS: begin
                if (valid_ok) state_n = NEXT;
            end
            NEXT: begin
                tog_n = ~tog_q;
                if (last_chan) begin
                    chan_n = '0;
                    led_n  = ~led0_o;
                end else begin
                    chan_n = chan_idx_o + 1'b1;
                end
                if (arm_trigger_i) begin
                    cnt_n   = p_clk_count_precharge_i;
                    azmux_n = hi_arr[chan_n];
                    swpc_n  = '0;
                    state_n = HI_PC;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counter, latched parameters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            count_q     <= '0;
            az_q        <= 1'b0;
            chan_idx_o  <= '0;
            azmux_o     <= '0;
            sw_pc_ctl_o <= '0;
            trig_q      <= 1'b0;
            tog_q       <= 1'b0;
            led0_o      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            count_q     <= count_n;
            az_q        <= az_n;
            chan_idx_o  <= chan_n;
            azmux_o     <= azmux_n;
            sw_pc_ctl_o <= swpc_n;
            trig_q      <= trig_n;
            tog_q       <= tog_n;
            led0_o      <= led_n;
        end
    end
endmodule

// File: tb/tb_sample_acquisition_az_multi.sv
// Directed bench for the multi-channel AZ sequencer: a vector table of run
// configurations with expected per-trigger outputs, plus hand-written corner cases.
module tb_sample_acquisition_az_multi;
    localparam int NCHAN = 4, AZMUX_W = 4, PC_W = 2, CNT_W = 24, IDX_W = 2;
    localparam logic [3:0]  LO     = 4'h5;
    localparam logic [1:0]  PCHI   = 2'b10;
    localparam logic [15:0] HIVALS = 16'hDCBA;

    logic clk = 1'b0;
    logic reset;
    logic arm, az;
    logic [IDX_W:0] ccount;
    logic [CNT_W-1:0] pc;
    logic [AZMUX_W-1:0] azmux;
    logic [PC_W-1:0] swpc;
    logic [IDX_W-1:0] chan;
    logic [2:0] status;
    logic led;
    logic [1:0] monitor;

    sample_acquisition_az_multi_if bus();

    sample_acquisition_az_multi #(.NCHAN(NCHAN), .AZMUX_W(AZMUX_W), .PC_W(PC_W),
                                  .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .adc(bus.master),
        .arm_trigger_i(arm), .az_enable_i(az),
        .p_azmux_lo_val_i(LO), .p_azmux_hi_vals_i(HIVALS),
        .p_chan_count_i(ccount), .p_sw_pc_ctl_hi_val_i(PCHI),
        .p_clk_count_precharge_i(pc),
        .azmux_o(azmux), .sw_pc_ctl_o(swpc), .chan_idx_o(chan),
        .status_o(status), .led0_o(led), .monitor_o(monitor)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          count;
        bit          az;
        int          pc;
        int          ntrig;
        logic [31:0] mux;   // expected azmux at trigger j: nibble j
        logic [15:0] ch;    // expected chan_idx at trigger j: bits [2j+:2]
        logic [7:0]  lo;    // expected phase_lo at trigger j
        int          nxt;   // status toggles seen by the last trigger
        int          leds;  // led toggles seen by the last trigger
    } vec_t;

    vec_t vecs [5];
    int tests = 0, fails = 0;
    int cyc = 0, hi_entry = 0, lo_entry = 0, nxt_cnt = 0, led_cnt = 0, trig_cnt = 0;
    logic p_run, p_tog, p_lo, p_led;
    logic trig;
    assign trig = bus.adc_measure_trig_o;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one cycle and sample on the falling edge; track phase entries and toggles.
    task step();
        @(negedge clk);
        cyc++;
        if (status[0] && (!p_run || status[2] != p_tog)) hi_entry = cyc;
        if (status[1] && !p_lo) lo_entry = cyc;
        if (status[2] != p_tog) nxt_cnt++;
        if (led != p_led) led_cnt++;
        if (trig) trig_cnt++;
        p_run = status[0]; p_tog = status[2]; p_lo = status[1]; p_led = led;
    endtask

    task clear_mon();
        nxt_cnt = 0; led_cnt = 0; trig_cnt = 0;
        p_run = status[0]; p_tog = status[2]; p_lo = status[1]; p_led = led;
    endtask

    task do_reset();
        reset = 1'b1; arm = 1'b0; bus.adc_measure_valid_i = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        clear_mon();
    endtask

    task automatic wait_trig(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (trig) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({nm, "_trig_timeout"}, 32'd1, 32'd0);
    endtask

    // ADC model: done pulse visible 5 clocks after the trigger cycle.
    task automatic adc_reply(input string nm);
        step();
        chk({nm, "_trig_width"}, trig, 1'b0);
        repeat (4) step();
        bus.adc_measure_valid_i = 1'b1;
        step();
        bus.adc_measure_valid_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        vec_t v;
        logic exp_lo;
        reset = 1'b1; arm = 1'b0; az = 1'b0; ccount = '0; pc = '0;
        bus.adc_measure_valid_i = 1'b0;

        //                  count az pc ntrig mux            ch        lo     nxt leds
        vecs[0] = '{count:2, az:1, pc:3, ntrig:6, mux:32'h005A5B5A, ch:16'h0050, lo:8'h2A, nxt:2, leds:1};
        vecs[1] = '{count:3, az:0, pc:1, ntrig:6, mux:32'h00CBACBA, ch:16'h0924, lo:8'h00, nxt:5, leds:1};
        vecs[2] = '{count:0, az:0, pc:0, ntrig:3, mux:32'h00000AAA, ch:16'h0000, lo:8'h00, nxt:2, leds:2};
        vecs[3] = '{count:7, az:0, pc:2, ntrig:6, mux:32'h00BADCBA, ch:16'h04E4, lo:8'h00, nxt:5, leds:1};
        vecs[4] = '{count:1, az:1, pc:0, ntrig:4, mux:32'h00005A5A, ch:16'h0000, lo:8'h0A, nxt:1, leds:1};

        // Reset state
        step(); step();
        chk("rst_azmux", azmux, 0);
        chk("rst_swpc", swpc, 0);
        chk("rst_chan", chan, 0);
        chk("rst_status", status, 0);
        chk("rst_led", led, 0);
        chk("rst_monitor", monitor, 0);
        chk("rst_trig", trig, 0);

        // Table-driven runs
        for (int n = 0; n < 5; n++) begin
            v = vecs[n];
            do_reset();
            ccount = v.count[IDX_W:0]; az = v.az; pc = v.pc[CNT_W-1:0];
            arm = 1'b1;
            for (int j = 0; j < v.ntrig; j++) begin
                wait_trig($sformatf("v%0d_t%0d", n, j), ok);
                if (!ok) break;
                exp_lo = v.lo[j];
                chk($sformatf("v%0d_t%0d_azmux", n, j), azmux, v.mux[j*4 +: 4]);
                chk($sformatf("v%0d_t%0d_chan", n, j), chan, v.ch[j*2 +: 2]);
                chk($sformatf("v%0d_t%0d_phase_lo", n, j), status[1], exp_lo);
                chk($sformatf("v%0d_t%0d_swpc", n, j), swpc, exp_lo ? 2'b00 : PCHI);
                chk($sformatf("v%0d_t%0d_settle", n, j), cyc - (exp_lo ? lo_entry : hi_entry), v.pc + 1);
                if (j == v.ntrig - 1) begin
                    chk($sformatf("v%0d_toggles", n), nxt_cnt, v.nxt);
                    chk($sformatf("v%0d_led", n), led_cnt, v.leds);
                end else begin
                    adc_reply($sformatf("v%0d_t%0d", n, j));
                end
            end
        end

        // Reset asserted while waiting in LO_MEAS
        do_reset();
        ccount = 2; az = 1'b1; pc = 1; arm = 1'b1;
        wait_trig("t1_hi", ok);
        adc_reply("t1_hi");
        wait_trig("t1_lo", ok);
        chk("t1_in_lo", status[1], 1'b1);
        step(); step();
        reset = 1'b1;
        #1;
        chk("t1_azmux", azmux, 0);
        chk("t1_swpc", swpc, 0);
        chk("t1_status", status, 0);
        chk("t1_monitor", monitor, 0);
        clear_mon();
        repeat (3) step();
        chk("t1_no_trig", trig_cnt, 0);
        arm = 1'b0;
        reset = 1'b0;
        step();
        chk("t1_idle_azmux", azmux, LO);
        chk("t1_idle_running", status[0], 1'b0);

        // Arm dropped during HI_MEAS: lo sample still runs, then idle
        do_reset();
        ccount = 2; az = 1'b1; pc = 2; arm = 1'b1;
        wait_trig("t5_hi", ok);
        arm = 1'b0;
        adc_reply("t5_hi");
        wait_trig("t5_lo", ok);
        chk("t5_lo_ran", status[1], 1'b1);
        adc_reply("t5_lo");
        repeat (10) step();
        chk("t5_toggles", nxt_cnt, 1);
        chk("t5_running", status[0], 1'b0);
        chk("t5_trigs", trig_cnt, 2);
        chk("t5_azmux", azmux, LO);
        chk("t5_chan", chan, 1);

        // Stray done pulses in HI_PC and on the trigger cycle are ignored
        do_reset();
        ccount = 2; az = 1'b1; pc = 4; arm = 1'b1;
        step(); step();
        bus.adc_measure_valid_i = 1'b1;
        step();
        bus.adc_measure_valid_i = 1'b0;
        wait_trig("t6_hi", ok);
        chk("t6_settle", cyc - hi_entry, 5);
        bus.adc_measure_valid_i = 1'b1;
        step();
        bus.adc_measure_valid_i = 1'b0;
        repeat (6) step();
        chk("t6_still_hi", status[1], 1'b0);
        chk("t6_running", status[0], 1'b1);
        chk("t6_trigs", trig_cnt, 1);
        bus.adc_measure_valid_i = 1'b1;
        step();
        bus.adc_measure_valid_i = 1'b0;
        wait_trig("t6_lo", ok);
        chk("t6_lo_after_valid", status[1], 1'b1);
        chk("t6_lo_settle", cyc - lo_entry, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
